// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared state encodings and default widths for the timer block
//
// Purpose: common definitions imported by timer_ctrl and tick_prescaler.
// Ports:   none (package).

package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } tmr_state_t;

  localparam int TMR_WIDTH   = 32;
  localparam int TMR_PRESC_W = 8;
  localparam int TMR_WRAP_W  = 16;

endpackage

// File: rtl/tick_prescaler.sv
// rtl/tick_prescaler.sv - clock divider producing one count-enable tick every div+1 cycles
//
// Purpose: divides clk down to the timer tick rate while the timer is running.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   run        : advance the divider this cycle
//   clr        : return the divider to 0 (wins over run)
//   div        : divider value Q; tick fires when the internal count equals Q
//   tick       : combinational count enable, only asserted while run is high

module tick_prescaler
  import timer_pkg::*;
#(
  parameter int PRESC_W = TMR_PRESC_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  input  logic               clr,
  input  logic [PRESC_W-1:0] div,
  output logic               tick
);

  logic [PRESC_W-1:0] presc_cnt;

  assign tick = run && (presc_cnt == div);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_cnt <= '0;
    end else if (clr) begin
      presc_cnt <= '0;
    end else if (run) begin
      presc_cnt <= tick ? '0 : presc_cnt + PRESC_W'(1);
    end
  end

endmodule

// File: rtl/timer_ctrl.sv
// rtl/timer_ctrl.sv - programmable one-shot/periodic timer sequencer with sticky irq
//
// Purpose: turns a prescaled tick into a timer with period P+1 ticks, pause via hold,
// abort via stop, period/done pulses, a saturating period counter and a sticky irq.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   start, stop    : single-cycle commands (stop > start > hold)
//   hold           : level, pauses counting while high
//   cfg_period     : terminal count P, latched on an accepted start
//   cfg_presc      : divider Q, latched on an accepted start
//   cfg_oneshot    : 1 = finish after one period, latched on an accepted start
//   irq_en, irq_clr: irq set enable, irq clear strobe
//   count, state, busy, period_pulse, done, irq, wrap_cnt : registered status outputs

module timer_ctrl
  import timer_pkg::*;
#(
  parameter int WIDTH   = TMR_WIDTH,
  parameter int PRESC_W = TMR_PRESC_W,
  parameter int WRAP_W  = TMR_WRAP_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               hold,
  input  logic [WIDTH-1:0]   cfg_period,
  input  logic [PRESC_W-1:0] cfg_presc,
  input  logic               cfg_oneshot,
  input  logic               irq_en,
  input  logic               irq_clr,
  output logic [WIDTH-1:0]   count,
  output logic [1:0]         state,
  output logic               busy,
  output logic               period_pulse,
  output logic               done,
  output logic               irq,
  output logic [WRAP_W-1:0]  wrap_cnt
);

  tmr_state_t         st_q, st_d;
  logic [WIDTH-1:0]   sh_period;
  logic [PRESC_W-1:0] sh_presc;
  logic               sh_oneshot;

  logic [WIDTH-1:0]   count_d;
  logic [WRAP_W-1:0]  wrap_d;
  logic               pulse_d, done_d, irq_d, busy_d;
  logic               load, presc_clr;
  logic               tick, terminal;

  assign state = st_q;

  tick_prescaler #(.PRESC_W(PRESC_W)) u_presc (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (st_q == ST_RUN),
    .clr   (presc_clr),
    .div   (sh_presc),
    .tick  (tick)
  );

  // Compare against the shadow period so the wrap never needs an add past all-ones.
  assign terminal = tick && (count == sh_period);

  always_comb begin
    st_d      = st_q;
    count_d   = count;
    wrap_d    = wrap_cnt;
    pulse_d   = 1'b0;
    done_d    = 1'b0;
    load      = 1'b0;
    presc_clr = 1'b0;

    if (stop) begin
      // Abort swallows any terminal tick on this edge; count is left for inspection.
      st_d      = ST_IDLE;
      presc_clr = 1'b1;
    end else if (start && (st_q == ST_IDLE || st_q == ST_DONE)) begin
      load      = 1'b1;
      presc_clr = 1'b1;
      count_d   = '0;
      wrap_d    = '0;
      st_d      = ST_RUN;
    end else begin
      unique case (st_q)
        ST_RUN: begin
          // A tick on the same edge that hold is seen is still applied.
          if (tick) begin
            if (terminal) begin
              count_d = '0;
              pulse_d = 1'b1;
              if (wrap_cnt != '1) wrap_d = wrap_cnt + WRAP_W'(1);
            end else begin
              count_d = count + WIDTH'(1);
            end
          end
          if (terminal && sh_oneshot) begin
            st_d   = ST_DONE;
            done_d = 1'b1;
          end else if (hold) begin
            st_d = ST_PAUSE;
          end
        end
        ST_PAUSE: if (!hold) st_d = ST_RUN;
        default: ;
      endcase
    end

    // Set beats clear when both land on the same edge.
    irq_d = irq_clr ? 1'b0 : irq;
    if (pulse_d && irq_en) irq_d = 1'b1;

    busy_d = (st_d == ST_RUN) || (st_d == ST_PAUSE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q         <= ST_IDLE;
      count        <= '0;
      wrap_cnt     <= '0;
      period_pulse <= 1'b0;
      done         <= 1'b0;
      irq          <= 1'b0;
      busy         <= 1'b0;
      sh_period    <= '0;
      sh_presc     <= '0;
      sh_oneshot   <= 1'b0;
    end else begin
      st_q         <= st_d;
      count        <= count_d;
      wrap_cnt     <= wrap_d;
      period_pulse <= pulse_d;
      done         <= done_d;
      irq          <= irq_d;
      busy         <= busy_d;
      if (load) begin
        sh_period  <= cfg_period;
        sh_presc   <= cfg_presc;
        sh_oneshot <= cfg_oneshot;
      end
    end
  end

endmodule

// File: tb/tb_timer_ctrl.sv
// tb/tb_timer_ctrl.sv - scoreboard bench for timer_ctrl

module tb_timer_ctrl;
  import timer_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, stop = 1'b0, hold = 1'b0;
  logic [31:0] cfg_period = '0;
  logic [7:0]  cfg_presc = '0;
  logic        cfg_oneshot = 1'b0;
  logic        irq_en = 1'b0, irq_clr = 1'b0;
  logic [31:0] count;
  logic [1:0]  state;
  logic        busy, period_pulse, done, irq;
  logic [15:0] wrap_cnt;

  timer_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .hold(hold),
    .cfg_period(cfg_period), .cfg_presc(cfg_presc), .cfg_oneshot(cfg_oneshot),
    .irq_en(irq_en), .irq_clr(irq_clr), .count(count), .state(state), .busy(busy),
    .period_pulse(period_pulse), .done(done), .irq(irq), .wrap_cnt(wrap_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cy;
    logic [31:0] cnt;
    logic        dn;
    logic [1:0]  st;
    logic [15:0] wr;
    logic        iq;
  } exp_t;

  exp_t sbq[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push(input int cy, input logic dn, input logic [1:0] st,
                      input logic [15:0] wr, input logic iq);
    exp_t e;
    e.cy = cy; e.cnt = '0; e.dn = dn; e.st = st; e.wr = wr; e.iq = iq;
    sbq.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [31:0] p, input logic [7:0] q, input logic os,
                          output int e);
    cfg_period = p; cfg_presc = q; cfg_oneshot = os;
    start = 1'b1;
    step(1);
    start = 1'b0;
    e = cyc;
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget && sbq.size() != 0; i++) step(1);
    check("drain", 64'(sbq.size()), 64'd0);
  endtask

  // Monitor: every period_pulse must match the next scoreboard entry.
  always @(negedge clk) begin
    if (rst_n && period_pulse) begin
      if (sbq.size() == 0) begin
        check("unexpected_pulse", 64'(cyc), 64'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("pulse_cycle", 64'(cyc),      64'(e.cy));
        check("pulse_count", 64'(count),    64'(e.cnt));
        check("pulse_done",  64'(done),     64'(e.dn));
        check("pulse_state", 64'(state),    64'(e.st));
        check("pulse_wrap",  64'(wrap_cnt), 64'(e.wr));
        check("pulse_irq",   64'(irq),      64'(e.iq));
      end
    end else if (rst_n && done) begin
      check("done_without_pulse", 64'(done), 64'd0);
    end
  end

  initial begin
    int e, e2;

    // Reset state, while held and after release.
    step(2);
    check("rst_state", 64'(state), 64'(ST_IDLE));
    check("rst_count", 64'(count), 64'd0);
    check("rst_busy",  64'(busy),  64'd0);
    check("rst_wrap",  64'(wrap_cnt), 64'd0);
    check("rst_irq",   64'(irq),   64'd0);
    rst_n = 1'b1;
    step(1);
    check("idle_state", 64'(state), 64'(ST_IDLE));
    check("idle_pulse", 64'({period_pulse, done}), 64'd0);

    // One-shot P=3 Q=0.
    do_start(32'd3, 8'd0, 1'b1, e);
    push(e + 4, 1'b1, ST_DONE, 16'd1, 1'b0);
    check("os_run_state", 64'(state), 64'(ST_RUN));
    check("os_busy", 64'(busy), 64'd1);
    check("os_count0", 64'(count), 64'd0);
    for (int k = 1; k <= 3; k++) begin
      step(1);
      check("os_count", 64'(count), 64'(k));
    end
    step(1);
    check("os_done_state", 64'(state), 64'(ST_DONE));
    check("os_done_busy", 64'(busy), 64'd0);
    step(1);
    check("os_pulse_once", 64'({period_pulse, done}), 64'd0);

    // Periodic P=2 Q=3 with irq: period of 12 cycles.
    irq_en = 1'b1;
    do_start(32'd2, 8'd3, 1'b0, e);
    push(e + 12, 1'b0, ST_RUN, 16'd1, 1'b1);
    push(e + 24, 1'b0, ST_RUN, 16'd2, 1'b1);
    push(e + 36, 1'b0, ST_RUN, 16'd3, 1'b1);
    push(e + 48, 1'b0, ST_RUN, 16'd4, 1'b1);
    step(36);
    check("per_wrap3", 64'(wrap_cnt), 64'd3);
    check("per_irq_sticky", 64'(irq), 64'd1);
    irq_clr = 1'b1;
    step(1);
    irq_clr = 1'b0;
    check("per_irq_clr", 64'(irq), 64'd0);
    step(11);
    check("per_wrap4", 64'(wrap_cnt), 64'd4);
    stop = 1'b1; irq_clr = 1'b1; irq_en = 1'b0;
    step(1);
    stop = 1'b0; irq_clr = 1'b0;
    check("per_stop_state", 64'(state), 64'(ST_IDLE));
    check("per_stop_irq", 64'(irq), 64'd0);

    // Hold for 4 edges starting at count=2 delays the pulse by 4.
    do_start(32'd5, 8'd0, 1'b0, e);
    push(e + 10, 1'b0, ST_RUN, 16'd1, 1'b0);
    step(1);
    hold = 1'b1;
    step(1);
    check("hold_pause_state", 64'(state), 64'(ST_PAUSE));
    check("hold_count_a", 64'(count), 64'd2);
    step(3);
    check("hold_count_b", 64'(count), 64'd2);
    hold = 1'b0;
    step(1);
    check("hold_resume_state", 64'(state), 64'(ST_RUN));
    check("hold_count_c", 64'(count), 64'd2);
    step(1);
    check("hold_count_d", 64'(count), 64'd3);
    wait_drain(20);
    stop = 1'b1;
    step(1);
    stop = 1'b0;

    // stop+start on a terminal tick: no pulse, count kept, start ignored.
    do_start(32'd3, 8'd0, 1'b0, e);
    step(3);
    stop = 1'b1; start = 1'b1;
    step(1);
    stop = 1'b0; start = 1'b0;
    check("stop_state", 64'(state), 64'(ST_IDLE));
    check("stop_count", 64'(count), 64'd3);
    check("stop_no_pulse", 64'({period_pulse, done}), 64'd0);
    check("stop_wrap", 64'(wrap_cnt), 64'd0);
    step(5);
    check("stop_idle_count", 64'(count), 64'd3);

    // P=0 Q=0: pulse every cycle, wrap_cnt saturates, irq set beats clear.
    irq_en = 1'b1;
    do_start(32'd0, 8'd0, 1'b0, e);
    for (int k = 1; k <= 65540; k++)
      push(e + k, 1'b0, ST_RUN, (k >= 65535) ? 16'hFFFF : 16'(k), 1'b1);
    step(9);
    irq_clr = 1'b1;
    step(1);
    irq_clr = 1'b0;
    check("p0_irq_set_wins", 64'(irq), 64'd1);
    step(65530);
    check("p0_wrap_sat", 64'(wrap_cnt), 64'hFFFF);
    check("p0_count", 64'(count), 64'd0);
    stop = 1'b1; irq_en = 1'b0; irq_clr = 1'b1;
    step(1);
    stop = 1'b0; irq_clr = 1'b0;
    check("p0_stop_irq", 64'(irq), 64'd0);
    wait_drain(4);

    // Config change mid-run only takes effect on the next start.
    irq_en = 1'b1;
    do_start(32'd3, 8'd0, 1'b0, e);
    push(e + 4, 1'b0, ST_RUN, 16'd1, 1'b1);
    push(e + 8, 1'b0, ST_RUN, 16'd2, 1'b1);
    step(1);
    cfg_period = 32'd9;
    step(8);
    check("shadow_count", 64'(count), 64'd1);
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    check("shadow_stop_count", 64'(count), 64'd1);
    do_start(32'd9, 8'd0, 1'b0, e2);
    push(e2 + 10, 1'b0, ST_RUN, 16'd1, 1'b1);
    step(12);
    check("new_period_count", 64'(count), 64'd2);

    // Asynchronous reset mid-run.
    rst_n = 1'b0;
    #1;
    check("arst_state", 64'(state), 64'(ST_IDLE));
    check("arst_count", 64'(count), 64'd0);
    check("arst_flags", 64'({busy, period_pulse, done, irq}), 64'd0);
    check("arst_wrap", 64'(wrap_cnt), 64'd0);
    step(1);
    rst_n = 1'b1;
    step(2);
    check("final_queue_empty", 64'(sbq.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/timer_ctrl.md
Name: timer_ctrl

Overview:
Sequencing controller for the team's up-counter datapath. It turns a free-running count into a programmable timer: prescaled count enable, terminal-count detection against a programmable period, one-shot or periodic modes, pause/resume, and a sticky interrupt. It sits between the register/CSR block, which drives the config and command inputs, and the interrupt aggregator.

Parameters:
WIDTH, 32, width of count and cfg_period
PRESC_W, 8, width of the prescaler divider value
WRAP_W, 16, width of the saturating period-completion counter

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous, active-low reset
start  in  1  single-cycle command: load config and run
stop  in  1  single-cycle command: abort to IDLE
hold  in  1  level: pause counting while high
cfg_period  in  WIDTH  terminal count P; one period is P+1 ticks
cfg_presc  in  PRESC_W  divider Q; one tick every Q+1 clk cycles
cfg_oneshot  in  1  1 = stop after first period, 0 = periodic
irq_en  in  1  enables irq set
irq_clr  in  1  single-cycle clear of irq
count  out  WIDTH  current count value
state  out  2  FSM state encoding
busy  out  1  high in RUN or PAUSE
period_pulse  out  1  one-cycle pulse per completed period
done  out  1  one-cycle pulse when a one-shot completes
irq  out  1  sticky interrupt
wrap_cnt  out  WRAP_W  saturating count of completed periods since last start

Behaviour:
- Reset values: state=IDLE, count=0, busy=0, period_pulse=0, done=0, irq=0, wrap_cnt=0, shadow config=0, prescaler=0.
- All outputs are registered.
- FSM states: IDLE=0, RUN=1, PAUSE=2, DONE=3.
- start in IDLE or DONE:
  - Latch cfg_period, cfg_presc and cfg_oneshot into shadow registers.
  - Clear count, prescaler and wrap_cnt; go to RUN.
  - start in RUN or PAUSE is ignored.
- Config changes while in RUN or PAUSE have no effect until the next start.
- Prescaler and tick:
  - Prescaler runs only in RUN.
  - tick = (presc_cnt == shadow Q). On tick, presc_cnt returns to 0; otherwise it increments.
- Counting, in RUN on tick:
  - If count != P: count increments by 1.
  - If count == P (terminal tick): count goes to 0 and period_pulse=1 next cycle.
  - wrap_cnt increments, saturating at all-ones.
  - Periodic mode: stay in RUN.
  - One-shot mode: go to DONE and done=1 in the same cycle as period_pulse.
- Latency: start sampled at edge E gives RUN at E. Terminal handling occurs at edge E+(P+1)(Q+1).
- P=0: every tick is terminal; count stays 0.
- Boundary P = all-ones: count reaches all-ones and wraps to 0 with period_pulse. No arithmetic overflow beyond WIDTH.
- hold:
  - RUN with hold=1 goes to PAUSE on the next edge; PAUSE with hold=0 returns to RUN.
  - count and presc_cnt are frozen in PAUSE.
  - A tick coincident with hold asserting is still applied on that edge.
- stop:
  - From any state goes to IDLE. count keeps its value; prescaler clears.
  - No period_pulse or done is generated, even if that cycle was a terminal tick.
- Priority: stop > start > hold.
- irq: set on a cycle producing period_pulse when irq_en=1; cleared by irq_clr. Simultaneous set and clear leaves irq=1.
- Reset mid-operation forces all reset values immediately, asynchronously.

Decomposition:
- Shared package timer_pkg holds:
  - state encodings (ST_IDLE, ST_RUN, ST_PAUSE, ST_DONE)
  - default widths (TMR_WIDTH=32, TMR_PRESC_W=8, TMR_WRAP_W=16)
- One sub-module, tick_prescaler: inputs clk, rst_n, run, clr, div; output tick.
- The FSM, counter, shadow registers and irq stay in timer_ctrl.

Test Plan:
- Reset, then P=3, Q=0, oneshot=1, start at edge E -> count 1,2,3 at E+1..E+3; at E+4 count=0, period_pulse=done=1 for one cycle, state=DONE, busy=0.
- P=2, Q=3, periodic, irq_en=1 -> period_pulse every 12 cycles; irq stays high after the first pulse until irq_clr; wrap_cnt=3 after 36 cycles.
- P=5, Q=0, periodic, hold high for 4 cycles at count=2 -> state=PAUSE, count holds 2 for 4 cycles, resumes to 3 after release; pulse delayed by exactly 4 cycles.
- Running, stop and start asserted in the same cycle as a terminal tick -> state=IDLE, no period_pulse or done, count holds its value, start ignored.
- P=0, Q=0, periodic -> period_pulse every cycle, count stays 0, wrap_cnt saturates at 0xFFFF; irq_clr with a coincident pulse leaves irq=1.
- Change cfg_period from 3 to 9 mid-RUN -> period stays 4 ticks until the next start, then becomes 10; rst_n low mid-RUN -> all outputs 0 immediately.
